// File: rtl/gpr_sb.sv
// Register file with write-back bypass and per-register busy scoreboard.
// Issue reserves a destination; write-back ports retire results and clear busy.
module gpr_sb #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NWB  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       rs1_addr,
  input  logic [AW-1:0]       rs2_addr,
  output logic [XLEN-1:0]     rs1_data,
  output logic [XLEN-1:0]     rs2_data,
  output logic                rs1_ready,
  output logic                rs2_ready,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*AW-1:0]   wb_addr,
  input  logic [NWB*XLEN-1:0] wb_data,
  input  logic                flush,
  output logic [AW:0]         busy_cnt,
  output logic                err_collide,
  output logic                err_stray
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_busy_cnt;
  logic            r_err_collide;
  logic            r_err_stray;

  logic [NREG-1:0] w_hit;
  logic [XLEN-1:0] w_hit_data [NREG];
  logic [NREG-1:0] w_busy_nxt;
  logic [AW:0]     w_cnt_nxt;
  logic            w_fire;
  logic            w_collide;
  logic            w_stray;

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_comb begin
    w_hit = '0;
    for (int r = 0; r < NREG; r++) w_hit_data[r] = '0;
    for (int i = 0; i < NWB; i++) begin
      if (wb_valid[i] && (wb_addr[i*AW +: AW] != '0)) begin
        w_hit[wb_addr[i*AW +: AW]]      = 1'b1;
        w_hit_data[wb_addr[i*AW +: AW]] = wb_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    w_collide = 1'b0;
    w_stray   = 1'b0;
    for (int i = 0; i < NWB; i++) begin
      if (wb_valid[i] && (wb_addr[i*AW +: AW] != '0)) begin
        if (!r_busy[wb_addr[i*AW +: AW]]) w_stray = 1'b1;
        for (int j = i + 1; j < NWB; j++) begin
          if (wb_valid[j] && (wb_addr[j*AW +: AW] == wb_addr[i*AW +: AW]))
            w_collide = 1'b1;
        end
      end
    end
  end

  assign iss_ready = (iss_rd == '0) | ~r_busy[iss_rd] | w_hit[iss_rd];
  assign w_fire    = iss_valid & iss_ready & (iss_rd != '0);

  // Priority: flush, then a new reservation, then write-back retirement.
  always_comb begin
    w_busy_nxt = r_busy;
    w_cnt_nxt  = '0;
    for (int r = 0; r < NREG; r++) begin
      if (w_hit[r]) w_busy_nxt[r] = 1'b0;
      if (w_fire && (iss_rd == AW'(r))) w_busy_nxt[r] = 1'b1;
      if (flush) w_busy_nxt[r] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;
    for (int r = 0; r < NREG; r++) w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[r]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
      r_busy        <= '0;
      r_busy_cnt    <= '0;
      r_err_collide <= 1'b0;
      r_err_stray   <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (w_hit[r]) r_regs[r] <= w_hit_data[r];
      end
      r_busy        <= w_busy_nxt;
      r_busy_cnt    <= w_cnt_nxt;
      r_err_collide <= r_err_collide | w_collide;
      r_err_stray   <= r_err_stray | w_stray;
    end
  end

  assign rs1_data    = w_hit[rs1_addr] ? w_hit_data[rs1_addr] : r_regs[rs1_addr];
  assign rs2_data    = w_hit[rs2_addr] ? w_hit_data[rs2_addr] : r_regs[rs2_addr];
  assign rs1_ready   = w_hit[rs1_addr] | ~r_busy[rs1_addr];
  assign rs2_ready   = w_hit[rs2_addr] | ~r_busy[rs2_addr];
  assign busy_cnt    = r_busy_cnt;
  assign err_collide = r_err_collide;
  assign err_stray   = r_err_stray;

endmodule

// File: tb/tb_gpr_sb.sv
// Bench for gpr_sb: two configurations (32x2 and 16x3) driven from shared stimulus,
// checked against a behavioural model through per-instance expectation queues.
module tb_gpr_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  s_rs1, s_rs2, s_iss_rd;
  logic        s_iss_valid, s_flush;
  logic [2:0]  s_wv;
  logic [3:0]  s_wa [3];
  logic [31:0] s_wd [3];

  logic [31:0] a_d1, a_d2, b_d1, b_d2;
  logic        a_r1, a_r2, a_ir, a_ec, a_es;
  logic        b_r1, b_r2, b_ir, b_ec, b_es;
  logic [5:0]  a_cnt;
  logic [4:0]  b_cnt;

  gpr_sb #(.XLEN(32), .NREG(32), .NWB(2)) u_a (
    .clk(clk), .rst(rst),
    .rs1_addr({1'b0, s_rs1}), .rs2_addr({1'b0, s_rs2}),
    .rs1_data(a_d1), .rs2_data(a_d2), .rs1_ready(a_r1), .rs2_ready(a_r2),
    .iss_valid(s_iss_valid), .iss_rd({1'b0, s_iss_rd}), .iss_ready(a_ir),
    .wb_valid(s_wv[1:0]), .wb_addr({1'b0, s_wa[1], 1'b0, s_wa[0]}),
    .wb_data({s_wd[1], s_wd[0]}), .flush(s_flush),
    .busy_cnt(a_cnt), .err_collide(a_ec), .err_stray(a_es)
  );

  gpr_sb #(.XLEN(32), .NREG(16), .NWB(3)) u_b (
    .clk(clk), .rst(rst),
    .rs1_addr(s_rs1), .rs2_addr(s_rs2),
    .rs1_data(b_d1), .rs2_data(b_d2), .rs1_ready(b_r1), .rs2_ready(b_r2),
    .iss_valid(s_iss_valid), .iss_rd(s_iss_rd), .iss_ready(b_ir),
    .wb_valid(s_wv), .wb_addr({s_wa[2], s_wa[1], s_wa[0]}),
    .wb_data({s_wd[2], s_wd[1], s_wd[0]}), .flush(s_flush),
    .busy_cnt(b_cnt), .err_collide(b_ec), .err_stray(b_es)
  );

  typedef struct {
    logic [31:0] d1, d2;
    logic r1, r2, ir, ec, es;
    int cnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [31:0] m_regs [2][16];
  logic        m_busy [2][16];
  int          m_cnt  [2];
  logic        m_ec   [2];
  logic        m_es   [2];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_lookup(input int k, input logic [3:0] a,
                                   output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    for (int i = 0; i < (k == 1 ? 3 : 2); i++)
      if (s_wv[i] && s_wa[i] == a && a != 0) begin
        h = 1'b1;
        d = s_wd[i];
      end
  endfunction

  function automatic exp_t m_exp(input int k);
    exp_t e;
    logic h;
    logic [31:0] d;
    m_lookup(k, s_rs1, h, d);
    e.d1 = h ? d : m_regs[k][s_rs1];
    e.r1 = h | !m_busy[k][s_rs1];
    m_lookup(k, s_rs2, h, d);
    e.d2 = h ? d : m_regs[k][s_rs2];
    e.r2 = h | !m_busy[k][s_rs2];
    m_lookup(k, s_iss_rd, h, d);
    e.ir  = (s_iss_rd == 0) | !m_busy[k][s_iss_rd] | h;
    e.cnt = m_cnt[k];
    e.ec  = m_ec[k];
    e.es  = m_es[k];
    return e;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 16; r++) begin
        m_regs[k][r] = '0;
        m_busy[k][r] = 1'b0;
      end
      m_cnt[k] = 0;
      m_ec[k]  = 1'b0;
      m_es[k]  = 1'b0;
    end
  endtask

  task automatic m_step();
    for (int k = 0; k < 2; k++) begin
      int nwb;
      exp_t e;
      logic fire, h;
      logic [31:0] d;
      logic nb [16];
      nwb  = (k == 1) ? 3 : 2;
      e    = m_exp(k);
      fire = s_iss_valid & e.ir & (s_iss_rd != 0);
      for (int i = 0; i < nwb; i++) begin
        if (s_wv[i] && s_wa[i] != 0) begin
          if (!m_busy[k][s_wa[i]]) m_es[k] = 1'b1;
          for (int j = i + 1; j < nwb; j++)
            if (s_wv[j] && s_wa[j] == s_wa[i]) m_ec[k] = 1'b1;
        end
      end
      m_cnt[k] = 0;
      for (int r = 0; r < 16; r++) begin
        m_lookup(k, 4'(r), h, d);
        nb[r] = m_busy[k][r];
        if (h) begin
          nb[r] = 1'b0;
          m_regs[k][r] = d;
        end
        if (fire && s_iss_rd == 4'(r)) nb[r] = 1'b1;
        if (s_flush || r == 0) nb[r] = 1'b0;
        m_busy[k][r] = nb[r];
        if (nb[r]) m_cnt[k]++;
      end
    end
  endtask

  task automatic cmp(input string p, input exp_t e, input logic [31:0] d1, input logic [31:0] d2,
                     input logic r1, input logic r2, input logic ir, input int cnt,
                     input logic ec, input logic es);
    check({p, "_rs1_data"}, d1, e.d1);
    check({p, "_rs2_data"}, d2, e.d2);
    check({p, "_rs1_ready"}, r1, e.r1);
    check({p, "_rs2_ready"}, r2, e.r2);
    check({p, "_iss_ready"}, ir, e.ir);
    check({p, "_busy_cnt"}, cnt, e.cnt);
    check({p, "_err_collide"}, ec, e.ec);
    check({p, "_err_stray"}, es, e.es);
  endtask

  task automatic push_exp();
    q_a.push_back(m_exp(0));
    q_b.push_back(m_exp(1));
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (q_a.size() == 0 || q_b.size() == 0) begin
      check("sb_empty", 64'(q_a.size() + q_b.size()), 64'd2);
    end else begin
      e = q_a.pop_front();
      cmp("a", e, a_d1, a_d2, a_r1, a_r2, a_ir, int'(a_cnt), a_ec, a_es);
      e = q_b.pop_front();
      cmp("b", e, b_d1, b_d2, b_r1, b_r2, b_ir, int'(b_cnt), b_ec, b_es);
    end
  endtask

  // Inputs are driven 1 time unit after posedge; outputs sampled before the next negedge.
  task automatic cyc();
    push_exp();
    #2;
    pop_cmp();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_iss_valid = 1'b0;
    s_flush     = 1'b0;
    s_wv        = '0;
    for (int i = 0; i < 3; i++) begin
      s_wa[i] = '0;
      s_wd[i] = '0;
    end
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    m_reset();
    push_exp();
    pop_cmp();
    check("rst_rs1_data", a_d1, 32'h0);
    check("rst_rs1_ready", a_r1, 1'b1);
    check("rst_busy_cnt", a_cnt, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    s_rs1 = '0;
    s_rs2 = '0;
    s_iss_rd = '0;
    idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 16; i++) begin
      s_rs1 = 4'(i);
      s_rs2 = 4'(15 - i);
      s_iss_rd = 4'(i);
      #1;
      check("init_rs1_data", a_d1, 32'h0);
      check("init_rs1_ready", b_r1, 1'b1);
      cyc();
    end

    // x0 writes and reservations are ignored
    s_rs1 = 0; s_iss_rd = 0; s_iss_valid = 1'b1;
    s_wv = 3'b001; s_wa[0] = 0; s_wd[0] = 32'hFFFF_FFFF;
    #1;
    check("x0_data", a_d1, 32'h0);
    check("x0_ready", a_r1, 1'b1);
    cyc();
    idle();
    #1;
    check("x0_cnt", a_cnt, 6'd0);
    check("x0_err", {a_ec, a_es, b_ec, b_es}, 4'b0);
    cyc();

    // reserve, stall on WAW, retire with bypass
    s_iss_valid = 1'b1; s_iss_rd = 5;
    cyc();
    s_rs1 = 5;
    #1;
    check("rsv_ready", a_r1, 1'b0);
    check("rsv_cnt", a_cnt, 6'd1);
    check("rsv_waw", a_ir, 1'b0);
    cyc();
    s_iss_valid = 1'b0;
    s_wv = 3'b001; s_wa[0] = 5; s_wd[0] = 32'hDEAD_BEEF;
    #1;
    check("wb_byp_data", a_d1, 32'hDEAD_BEEF);
    check("wb_byp_ready", a_r1, 1'b1);
    check("wb_byp_iss", a_ir, 1'b1);
    cyc();
    idle();
    #1;
    check("wb_cnt", a_cnt, 6'd0);
    check("wb_stored", b_d1, 32'hDEAD_BEEF);
    cyc();

    // asynchronous reset mid-traffic
    s_iss_valid = 1'b1; s_iss_rd = 6;
    cyc();
    s_iss_rd = 8;
    cyc();
    s_rs1 = 5; s_rs2 = 6;
    do_reset();

    // collision with a reserved target, then a stray write
    s_iss_valid = 1'b1; s_iss_rd = 3;
    cyc();
    idle();
    s_rs1 = 3;
    s_wv = 3'b011; s_wa[0] = 3; s_wa[1] = 3; s_wd[0] = 32'h1; s_wd[1] = 32'h2;
    #1;
    check("col_byp", a_d1, 32'h2);
    cyc();
    idle();
    #1;
    check("col_flag", a_ec, 1'b1);
    check("col_stored", a_d1, 32'h2);
    check("col_no_stray", a_es, 1'b0);
    s_wv = 3'b001; s_wa[0] = 9; s_wd[0] = 32'h99;
    cyc();
    idle();
    #1;
    check("stray_flag", a_es, 1'b1);
    check("col_sticky", a_ec, 1'b1);
    cyc();

    // port2 exists only on the 16x3 instance
    s_rs1 = 4;
    s_wv = 3'b101; s_wa[0] = 4; s_wa[2] = 4; s_wd[0] = 32'h44; s_wd[2] = 32'h55;
    #1;
    check("p2_byp_b", b_d1, 32'h55);
    check("p2_byp_a", a_d1, 32'h44);
    cyc();
    idle();

    // reservation and write-back to the same register in one cycle
    s_iss_valid = 1'b1; s_iss_rd = 7;
    s_wv = 3'b010; s_wa[1] = 7; s_wd[1] = 32'h1234_5678;
    cyc();
    idle();
    s_rs2 = 7;
    #1;
    check("rw_ready", a_r2, 1'b0);
    check("rw_data", a_d2, 32'h1234_5678);
    check("rw_cnt", a_cnt, 6'd1);
    cyc();

    // flush with concurrent write-back and issue
    for (int r = 11; r <= 14; r++) begin
      s_iss_valid = 1'b1; s_iss_rd = 4'(r);
      cyc();
    end
    s_flush = 1'b1; s_iss_rd = 10;
    s_wv = 3'b001; s_wa[0] = 12; s_wd[0] = 32'h00C0_FFEE;
    cyc();
    idle();
    s_rs1 = 12; s_rs2 = 10;
    #1;
    check("fl_cnt", a_cnt, 6'd0);
    check("fl_data", a_d1, 32'h00C0_FFEE);
    check("fl_rd10", b_r2, 1'b1);
    cyc();

    do_reset();
    for (int n = 0; n < 400; n++) begin
      s_rs1       = 4'($urandom_range(0, 15));
      s_rs2       = 4'($urandom_range(0, 15));
      s_iss_rd    = 4'($urandom_range(0, 15));
      s_iss_valid = ($urandom_range(0, 1) == 1);
      s_flush     = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 3; i++) begin
        s_wv[i] = ($urandom_range(0, 2) == 0);
        s_wa[i] = 4'($urandom_range(0, 15));
        s_wd[i] = $urandom;
      end
      cyc();
    end
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gpr_sb.md
# gpr_sb

Parametrised general-purpose register file with integrated scoreboard for the pipelined NPC core. It replaces the single-write-port register file used by the single-cycle core. It provides two combinational read ports with same-cycle write-back bypass, a configurable number of write-back ports, and per-register busy tracking for issue-stage RAW/WAW hazard detection, with flush support. Decode/issue reads operands and reserves destinations; write-back ports (ALU, LSU, CSR) retire results.

## Interface
- XLEN, 32, register width in bits
- NREG, 32, number of architectural registers (32 for RV32I, 16 for RV32E; power of two)
- NWB, 2, number of write-back ports (1..4)
- AW, $clog2(NREG), register address width (derived, not overridden)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- rs1_addr  input  AW  read port 1 address
- rs2_addr  input  AW  read port 2 address
- rs1_data  output  XLEN  read port 1 data (combinational, bypassed)
- rs2_data  output  XLEN  read port 2 data (combinational, bypassed)
- rs1_ready  output  1  rs1 value valid (not awaiting a producer)
- rs2_ready  output  1  rs2 value valid
- iss_valid  input  1  issue stage requests reservation of iss_rd
- iss_rd  input  AW  destination to reserve
- iss_ready  output  1  reservation accepted this cycle (no WAW hazard)
- wb_valid  input  NWB  per-port write-back strobe
- wb_addr  input  NWB*AW  port i address at [i*AW +: AW]
- wb_data  input  NWB*XLEN  port i data at [i*XLEN +: XLEN]
- flush  input  1  clear all busy bits (pipeline squash)
- busy_cnt  output  AW+1  registered count of busy registers
- err_collide  output  1  sticky: two valid write-back ports targeted the same nonzero register in one cycle
- err_stray  output  1  sticky: write-back to a nonzero register that was not busy

## Operation
- Storage: regs[NREG] of XLEN, busy[NREG] bits. Register 0 reads 0, ready=1, never busy; writes and reservations to 0 are ignored. These do not trigger error flags.
- Write-back hit for address a: any wb_valid[i] with wb_addr_i == a != 0. On collision, the highest port index wins for both data and bypass.
- Read: if a write-back hit exists for rsN_addr, rsN_data = winning wb_data and rsN_ready = 1. Otherwise rsN_data = regs[addr] and rsN_ready = !busy[addr].
- iss_ready = (iss_rd == 0) | !busy[iss_rd] | wb hit on iss_rd. This holds independent of iss_valid. Issue fire = iss_valid & iss_ready.
- Next-state per register r != 0, priority high to low:
  - flush: busy[r] <= 0.
  - fire on r: busy[r] <= 1. The new producer wins over a same-cycle write-back.
  - wb hit on r: busy[r] <= 0.
- regs[r] <= winning wb_data on any wb hit, including under flush.
- busy_cnt: registered popcount of next busy vector. It equals the popcount of busy[] after each edge.
- err_collide sets when ≥2 valid ports share a nonzero address. err_stray sets when a valid port targets nonzero r with busy[r]=0 before the edge. Both stay set until rst.
- Reset, mid-operation: all regs, busy, busy_cnt, and errors are forced to 0 immediately, regardless of clk.

## Timing
- Reset values: rs1/rs2_data 0, rs1/rs2_ready 1, iss_ready 1, busy_cnt 0, err_collide 0, err_stray 0.
- Read latency 0 (combinational), including bypass of same-cycle write-back.
- Write visible from regs[] from the cycle after the edge.
- Reservation visible (ready drops) the cycle after fire. In the fire cycle itself, reads of iss_rd still reflect the pre-fire state.
- Flush takes effect at the next edge; busy_cnt reads 0 the cycle after.
- No handshake back-pressure on write-back: every wb_valid is consumed in its cycle.

## Test plan
- Reset then read all addresses:
  - rs1_data = 0 and rs1_ready = 1 everywhere.
  - iss_ready = 1, busy_cnt = 0.
  - Assert rst mid-traffic → all outputs return to these values asynchronously.
- Issue rd=5, next cycle read rs1=5 → rs1_ready = 0, busy_cnt = 1, and iss_valid with rd=5 gives iss_ready = 0. Then wb port0 addr 5 data 0xDEADBEEF:
  - Same cycle: rs1_data = 0xDEADBEEF, rs1_ready = 1, iss_ready = 1.
  - Next cycle: busy_cnt = 0 and the regfile holds the value.
- Same cycle: issue rd=7 while wb port1 writes 7 with 0x12345678.
  - Next cycle: busy[7] = 1 (rs2_ready = 0), rs2_data = 0x12345678, busy_cnt = 1.
- Collision: wb port0 and port1 both write address 3 (0x1 and 0x2).
  - Same-cycle bypass and stored value = 0x2; err_collide = 1 next cycle and stays set.
  - Write to unreserved register 9 → err_stray = 1.
- Reserve 4 registers, then assert flush together with a wb to one of them and a new issue of rd=10.
  - Next cycle: busy_cnt = 0, the wb data is stored, and register 10 is not busy.
- Write rd=0 and issue rd=0 → reads of x0 return 0, ready = 1, busy_cnt unchanged, no error flags.
- Repeat with NREG=16 and NWB=3 → same results, addresses 0..15.
